// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment displays:
// hex font, dark patterns and digit count.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} for 0..F
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment pattern.
// Combinational; shared with the LED/debug displays.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nib];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit hex display of the CPU result word,
// with a once-per-frame snapshot and flags on decimal points.
module seg_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic [31:0]           dina,
  input  logic                  zfa,
  input  logic                  ofa,
  input  logic                  hold,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div;
  logic [2:0]    digit;
  logic [31:0]   snap_data;
  logic          snap_z;
  logic          snap_o;

  logic          div_end;
  logic          frame_end;
  logic [3:0]    nib;
  logic [6:0]    font_seg;
  logic          blank;

  logic [NUM_DIGITS-1:0] an_nx;
  logic [6:0]            seg_nx;
  logic                  dp_nx;

  assign div_end   = (div == DIV_MAX);
  assign frame_end = div_end && (digit == 3'd7);
  assign nib       = snap_data[{digit, 2'b00} +: 4];

  hex_to_seg7 u_font (
    .nib (nib),
    .seg (font_seg)
  );

  // Leading zero: this nibble and all above it are zero
  always_comb begin
    blank = 1'b0;
    if (BLANK_LZ && digit != 3'd0)
      blank = ((snap_data >> {digit, 2'b00}) == 32'd0);
  end

  always_comb begin
    an_nx  = AN_OFF;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    if (!blank) begin
      an_nx[digit] = 1'b0;
      seg_nx       = font_seg;
      dp_nx        = ~((digit == 3'd0 && snap_z) ||
                       (digit == 3'd7 && snap_o));
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      div       <= '0;
      digit     <= '0;
      snap_data <= '0;
      snap_z    <= 1'b0;
      snap_o    <= 1'b0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      div <= div_end ? '0 : div + 1'b1;
      if (div_end)
        digit <= digit + 3'd1;
      if (frame_end && !hold) begin
        snap_data <= dina;
        snap_z    <= zfa;
        snap_o    <= ofa;
      end
      an  <= an_nx;
      seg <= seg_nx;
      dp  <= dp_nx;
    end
  end

endmodule
